// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg -- shared definitions for the ALU execution unit.
//   DATA_W  : operand/result width (fixed at 32)
//   MUL_CNT_W : width of the iterative multiplier step counter
//   op_e    : 3-bit operation codes accepted on req_ctr
//   state_e : control FSM encoding (IDLE / MUL / RESP)
package alu_exec_pkg;

  localparam int DATA_W    = 32;
  localparam int MUL_CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_SLT = 3'b100,
    OP_ADD = 3'b101,
    OP_SUB = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_exec_mul.sv
// alu_exec_mul -- iterative shift-add multiplier, one partial product per cycle.
// Produces the low DATA_W bits of a*b after DATA_W steps.
//   clk, reset : clock, synchronous active-high reset
//   start      : load operands, clear accumulator and step counter
//   a, b       : multiplicand / multiplier, sampled when start is high
//   done       : high during the final step; product is valid in that cycle
//   product    : low word of a*b (meaningful only while done is high)
module alu_exec_mul
  import alu_exec_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  logic [DATA_W-1:0]    mcand_q;
  logic [DATA_W-1:0]    mplier_q;
  logic [DATA_W-1:0]    acc_q;
  logic [MUL_CNT_W-1:0] cnt_q;
  logic                 busy_q;
  logic [DATA_W-1:0]    acc_next;

  // Multiplicand shifts left and multiplier shifts right, so each step only
  // inspects bit 0; bits shifted past DATA_W never reach the low word.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done     = busy_q && (cnt_q == MUL_CNT_W'(DATA_W - 1));
  // The last step's sum is handed out directly so the caller can register
  // it on the same edge that completes step DATA_W-1.
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + MUL_CNT_W'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- handshaked wrapper around a 32-bit combinational ALU.
// Requests (code + two operands) arrive on a valid/ready channel; results
// leave on a registered valid/ready response channel.
// Optional feature macro: ALU_EXEC_MUL_EN -- when defined, code 111 runs the
// iterative multiplier (32 cycles); otherwise code 111 answers in one cycle
// with result 0 and resp_err set.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake
//   req_ctr             : operation code (see alu_exec_pkg::op_e)
//   req_src1, req_src2  : operands A and B
//   resp_valid/resp_ready : response handshake
//   resp_result         : operation result
//   resp_zero           : resp_result == 0
//   resp_err            : unsupported operation
module alu_exec_unit
  import alu_exec_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_ctr,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              resp_err
);

  state_e            state_q;
  state_e            state_next;
  op_e               op;
  logic              accept;
  logic              is_mul;
  logic [DATA_W-1:0] alu_result;
  logic              alu_err;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  assign op     = op_e'(req_ctr);
  assign accept = req_valid && req_ready;

  // ---------------------------------------------------------------------------
  // Combinational ALU datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    alu_result = '0;
    alu_err    = 1'b0;
    unique case (op)
      OP_AND: alu_result = req_src1 & req_src2;
      OP_OR:  alu_result = req_src1 | req_src2;
      OP_XOR: alu_result = req_src1 ^ req_src2;
      OP_NOR: alu_result = ~(req_src1 | req_src2);
      OP_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(req_src1) < $signed(req_src2))};
      OP_ADD: alu_result = req_src1 + req_src2;
      OP_SUB: alu_result = req_src1 - req_src2;
      OP_MUL: alu_err    = 1'b1;  // only reached when the multiplier is absent
      default: alu_err   = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional iterative multiplier
  // ---------------------------------------------------------------------------
`ifdef ALU_EXEC_MUL_EN
  assign is_mul = (op == OP_MUL);

  alu_exec_mul u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && is_mul),
    .a       (req_src1),
    .b       (req_src2),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign is_mul      = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of block ordering.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    req_ready  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = is_mul ? ST_MUL : ST_RESP;
      end
      ST_MUL: begin
        if (mul_done) state_next = ST_RESP;
      end
      ST_RESP: begin
        // Ready follows the consumer so a response hand-off and the next
        // request can share one edge.
        req_ready = resp_ready;
        if (resp_ready) begin
          if (req_valid) state_next = is_mul ? ST_MUL : ST_RESP;
          else           state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign resp_valid = (state_q == ST_RESP);

  // ---------------------------------------------------------------------------
  // Response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the response datapath is reset too, because its contents are
    // visible on the outputs and must read 0 straight after reset.
    if (reset) begin
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else if (accept && !is_mul) begin
      resp_result <= alu_result;
      resp_zero   <= (alu_result == '0);
      resp_err    <= alu_err;
    end else if (mul_done) begin
      resp_result <= mul_product;
      resp_zero   <= (mul_product == '0);
      resp_err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit -- scoreboard bench for alu_exec_unit. Stimulus pushes
// expected responses into a queue; an independent monitor pops and compares
// on every response handshake and checks that held responses stay stable.
module tb_alu_exec_unit;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_ctr;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic        resp_err;

  int   total = 0;
  int   bad   = 0;
  int   rr_mode = 1;  // 0: hold low, 1: hold high, 2: random
  exp_t sb_q[$];

  localparam int WAIT_LIMIT = 200;

  alu_exec_unit dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_ctr     (req_ctr),
    .req_src1    (req_src1),
    .req_src2    (req_src2),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_err    (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: the operation table as plain arithmetic.
  function automatic exp_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.err = 1'b0;
    case (c)
      3'd0: e.result = a & b;
      3'd1: e.result = a | b;
      3'd2: e.result = a ^ b;
      3'd3: e.result = ~(a | b);
      3'd4: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: e.result = a + b;
      3'd6: e.result = a - b;
      default: begin
`ifdef ALU_EXEC_MUL_EN
        e.result = a * b;
`else
        e.result = 32'd0;
        e.err    = 1'b1;
`endif
      end
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  // Consumer readiness, changed away from both the active edge and the
  // monitor's sampling edge.
  initial forever begin
    @(posedge clk);
    #2;
    case (rr_mode)
      0:       resp_ready = 1'b0;
      1:       resp_ready = 1'b1;
      default: resp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compare on handshake, check stability while held.
  initial begin
    logic        held = 1'b0;
    logic [31:0] h_result;
    logic        h_zero;
    logic        h_err;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", resp_valid, 1'b1);
          check("hold_result", resp_result, h_result);
          check("hold_flags", {resp_zero, resp_err}, {h_zero, h_err});
        end
        if (resp_valid && resp_ready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("resp_result", resp_result, e.result);
            check("resp_zero", resp_zero, e.zero);
            check("resp_err", resp_err, e.err);
          end
          held = 1'b0;
        end else if (resp_valid) begin
          held     = 1'b1;
          h_result = resp_result;
          h_zero   = resp_zero;
          h_err    = resp_err;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  // Issue one request; returns after the accepting edge (+1). Fields are
  // scrambled afterwards to show they are sampled only on acceptance.
  task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                      output int waits);
    req_valid = 1'b1;
    req_ctr   = c;
    req_src1  = a;
    req_src2  = b;
    waits     = 0;
    @(negedge clk);
    while (!req_ready && waits < WAIT_LIMIT) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    sb_q.push_back(model(c, a, b));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_ctr   = 3'($urandom);
    req_src1  = $urandom;
    req_src2  = $urandom;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int w;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_ctr   = 3'd0;
    req_src1  = '0;
    req_src2  = '0;
    rr_mode   = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_result", resp_result, 32'd0);
    check("rst_flags", {resp_zero, resp_err}, 2'b00);
    check("rst_req_ready", req_ready, 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Logic / arithmetic ops, one cycle latency each.
    send(3'b000, 32'hAAAA_5555, 32'h00FF_00FF, w); check("lat_and", resp_valid, 1'b1);
    send(3'b001, 32'hAAAA_5555, 32'h00FF_00FF, w); check("lat_or", resp_valid, 1'b1);
    send(3'b010, 32'hAAAA_5555, 32'h00FF_00FF, w); check("lat_xor", resp_valid, 1'b1);
    send(3'b101, 32'h1100_0011, 32'h1000_0011, w); check("lat_add", resp_valid, 1'b1);
    send(3'b110, 32'h0000_0005, 32'h0000_0005, w); check("lat_sub", resp_valid, 1'b1);
    send(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, w); check("lat_slt", resp_valid, 1'b1);
    send(3'b011, 32'h0F0F_0000, 32'h0000_F0F0, w); check("lat_nor", resp_valid, 1'b1);
    @(posedge clk);
    #1;

    // Multiply: latency and ready behaviour.
    rr_mode = 0;
    @(posedge clk);
    #1;
    send(3'b111, 32'h0001_0003, 32'h0002_0005, w);
`ifdef ALU_EXEC_MUL_EN
    for (int i = 0; i < 32; i++) begin
      check("mul_busy", {resp_valid, req_ready}, 2'b00);
      @(posedge clk);
      #1;
    end
    check("mul_lat", resp_valid, 1'b1);
`else
    check("mul_off_lat", resp_valid, 1'b1);
`endif
    rr_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    check("mul_drained", sb_q.size(), 32'd0);

    // Backpressure: response held 5 cycles, next request waits, then both
    // handshakes complete on one edge.
    rr_mode = 0;
    @(posedge clk);
    #1;
    send(3'b101, 32'h0000_1234, 32'h0000_4321, w);
    req_valid = 1'b1;
    req_ctr   = 3'b010;
    req_src1  = 32'hDEAD_BEEF;
    req_src2  = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_req_ready", req_ready, 1'b0);
      check("bp_resp_valid", resp_valid, 1'b1);
    end
    @(posedge clk);
    #1;
    rr_mode = 1;
    @(negedge clk);
    check("bp_release_accept", {req_ready, resp_valid}, 2'b11);
    sb_q.push_back(model(3'b010, 32'hDEAD_BEEF, 32'hFFFF_0000));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("bp_new_resp", resp_valid, 1'b1);
    @(posedge clk);
    #1;

    // Streaming: 8 ADDs, one per cycle.
    for (int i = 0; i < 8; i++) begin
      send(3'b101, 32'(i * 3), 32'h0000_0100, w);
      check("stream_wait", w, 0);
      check("stream_valid", resp_valid, 1'b1);
    end
    @(posedge clk);
    #1;
    check("stream_drained", sb_q.size(), 32'd0);

    // Reset during a multiply (or during a held response without it).
    rr_mode = 0;
    @(posedge clk);
    #1;
    send(3'b111, 32'h1234_5678, 32'h0000_0003, w);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    check("mrst_resp_valid", resp_valid, 1'b0);
    check("mrst_result", resp_result, 32'd0);
    check("mrst_flags", {resp_zero, resp_err}, 2'b00);
    check("mrst_req_ready", req_ready, 1'b1);
    rr_mode = 1;
    send(3'b101, 32'd1, 32'd1, w);
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure and idle gaps.
    rr_mode = 2;
    for (int i = 0; i < 250; i++) begin
      send(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), w);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rr_mode = 1;
    for (int i = 0; i < WAIT_LIMIT && sb_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check("final_drain", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
